// File: rtl/telem_frame_pkg.sv
// Shared constants, frame sizing helper, framer state type and payload CRC
// for the telemetry frame serializer.
// Optional build macro: TELEM_FRAME_SERIALIZER_CRC_EN (appends CRC-8 to each frame).
`timescale 1ns/1ps
package telem_frame_pkg;

    localparam int              PKT_W     = 88;
    localparam int              SYNC_W    = 16;
    localparam logic [SYNC_W-1:0] SYNC_WORD = 16'hEB90;

    localparam logic [7:0]      CRC_POLY  = 8'h07;
    localparam logic [7:0]      CRC_INIT  = 8'h00;

`ifdef TELEM_FRAME_SERIALIZER_CRC_EN
    localparam int              CRC_W     = 8;
`else
    localparam int              CRC_W     = 0;
`endif

    // Number of nibbles in one frame: sync + payload (+ optional CRC).
    function automatic int frame_nibbles(input int crc_w);
        return (SYNC_W + PKT_W + crc_w) / 4;
    endfunction

    localparam int FRAME_NIB = frame_nibbles(CRC_W);
    localparam int FRAME_W   = FRAME_NIB * 4;
    localparam int CNT_W     = $clog2(FRAME_NIB);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

`ifdef TELEM_FRAME_SERIALIZER_CRC_EN
    // CRC-8 over the payload only, MSB first, no reflection, no final XOR.
    function automatic logic [7:0] crc8(input logic [PKT_W-1:0] data);
        logic [7:0] crc;
        crc = CRC_INIT;
        for (int i = PKT_W - 1; i >= 0; i--) begin
            if (crc[7] ^ data[i]) crc = {crc[6:0], 1'b0} ^ CRC_POLY;
            else                  crc = {crc[6:0], 1'b0};
        end
        return crc;
    endfunction
`endif

endpackage

// File: rtl/telem_nibble_gearbox.sv
// clk4x-domain gearbox: turns one framer nibble per clk_128 cycle into four
// serial bits, bit 3 first, on the O/OB pseudo-differential pair.
// The framer toggles 'phase' every clk_128 cycle; the toggle edge marks when
// the nibble register is stable and may be captured.
`timescale 1ns/1ps
module telem_nibble_gearbox (
    input  logic       clk4x,
    input  logic       ft_reset,
    input  logic       phase,
    input  logic [3:0] nibble,
    output logic       O,
    output logic       OB
);

    logic       rst_meta;
    logic       rst_sync;
    logic       phase_p0;
    logic       phase_p1;
    logic       phase_p2;
    logic       load;
    logic [3:0] shreg;

    // Reset synchroniser: assert immediately, release after two clk4x edges.
    always_ff @(posedge clk4x or posedge ft_reset) begin
        if (ft_reset) begin
            rst_meta <= 1'b1;
            rst_sync <= 1'b1;
        end else begin
            rst_meta <= 1'b0;
            rst_sync <= rst_meta;
        end
    end

    // Phase sampling: two sampling flops plus one for edge detection.
    always_ff @(posedge clk4x or posedge rst_sync) begin
        if (rst_sync) begin
            phase_p0 <= 1'b0;
            phase_p1 <= 1'b0;
            phase_p2 <= 1'b0;
        end else begin
            // stage p0 -> p1 -> p2
            phase_p0 <= phase;
            phase_p1 <= phase_p0;
            phase_p2 <= phase_p1;
        end
    end

    // One load strobe per framer cycle, three clk4x edges after the toggle.
    assign load = phase_p1 ^ phase_p2;

    // Nibble shift register: capture on load, otherwise shift out MSB first.
    always_ff @(posedge clk4x or posedge rst_sync) begin
        if (rst_sync) begin
            shreg <= 4'h0;
        end else if (load) begin
            shreg <= nibble;
        end else begin
            shreg <= {shreg[2:0], 1'b0};
        end
    end

    assign O  = shreg[3];
    assign OB = ~shreg[3];

endmodule

// File: rtl/telem_frame_serializer.sv
// Telemetry frame serializer top: clk_128 framer that wraps each 88-bit
// packet as {SYNC_WORD, packet [, CRC-8]} and emits it one nibble per cycle
// to the clk4x gearbox, which drives the serial O/OB pair.
// Optional build macro: TELEM_FRAME_SERIALIZER_CRC_EN (28-nibble frames with CRC).
`timescale 1ns/1ps
module telem_frame_serializer
    import telem_frame_pkg::*;
(
    input  logic             clk_128,
    input  logic             clk4x,
    input  logic             ft_reset,
    input  logic [PKT_W-1:0] packet,
    input  logic             packet_valid,
    output logic             serializer_ready,
    output logic             O,
    output logic             OB
);

    state_t             state_q;
    state_t             state_d;
    logic [FRAME_W-1:0] frame_q;
    logic [FRAME_W-1:0] frame_init;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         nibble_q;
    logic               phase_q;
    logic               ready_q;
    logic               ready_d;
    logic               load_frame;
    logic               shift_frame;
    logic               end_frame;

`ifdef TELEM_FRAME_SERIALIZER_CRC_EN
    assign frame_init = {SYNC_WORD, packet, crc8(packet)};
`else
    assign frame_init = {SYNC_WORD, packet};
`endif

    // State register; ready is registered so it stays low through reset.
    always_ff @(posedge clk_128 or posedge ft_reset) begin
        if (ft_reset) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic: accept from IDLE, leave SEND once the count is spent.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (packet_valid && ready_q) state_d = ST_SEND;
            ST_SEND: if (cnt_q == '0)             state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    // Output decode: datapath strobes and the next value of ready.
    always_comb begin
        load_frame  = 1'b0;
        shift_frame = 1'b0;
        end_frame   = 1'b0;
        ready_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_frame = packet_valid && ready_q;
                ready_d    = !load_frame;
            end
            ST_SEND: begin
                shift_frame = (cnt_q != '0);
                end_frame   = (cnt_q == '0);
                ready_d     = end_frame;
            end
            default: ready_d = 1'b0;
        endcase
    end

    // Frame shifter: first nibble leaves on the accept edge, rest follow.
    always_ff @(posedge clk_128 or posedge ft_reset) begin
        if (ft_reset) begin
            frame_q  <= '0;
            cnt_q    <= '0;
            nibble_q <= 4'h0;
        end else if (load_frame) begin
            frame_q  <= {frame_init[FRAME_W-5:0], 4'h0};
            nibble_q <= frame_init[FRAME_W-1 -: 4];
            cnt_q    <= CNT_W'(FRAME_NIB - 1);
        end else if (shift_frame) begin
            frame_q  <= {frame_q[FRAME_W-5:0], 4'h0};
            nibble_q <= frame_q[FRAME_W-1 -: 4];
            cnt_q    <= cnt_q - CNT_W'(1);
        end else if (end_frame) begin
            nibble_q <= 4'h0;
        end
    end

    // Phase toggle marks each new nibble for the clk4x gearbox.
    always_ff @(posedge clk_128 or posedge ft_reset) begin
        if (ft_reset) phase_q <= 1'b0;
        else          phase_q <= ~phase_q;
    end

    assign serializer_ready = ready_q;

    telem_nibble_gearbox u_gearbox (
        .clk4x    (clk4x),
        .ft_reset (ft_reset),
        .phase    (phase_q),
        .nibble   (nibble_q),
        .O        (O),
        .OB       (OB)
    );

endmodule

// File: tb/tb_telem_frame_serializer.sv
// Directed bench for telem_frame_serializer: records O on every clk4x cycle
// and checks framing, bit order, constant latency, ready timing and reset.
`timescale 1ns/1ps
module tb_telem_frame_serializer;

    localparam int PW = 88;
`ifdef TELEM_FRAME_SERIALIZER_CRC_EN
    localparam int FW  = 112;
    localparam int NIB = 28;
`else
    localparam int FW  = 104;
    localparam int NIB = 26;
`endif
    localparam int OBUF_N = 16384;

    logic          clk_128;
    logic          clk4x;
    logic          ft_reset;
    logic [PW-1:0] packet;
    logic          packet_valid;
    logic          serializer_ready;
    logic          O;
    logic          OB;

    int   total = 0;
    int   bad = 0;
    int   nbits = 0;
    int   ob_bad = 0;
    int   lat_ref = 0;
    logic obuf [OBUF_N];

    telem_frame_serializer dut (
        .clk_128          (clk_128),
        .clk4x            (clk4x),
        .ft_reset         (ft_reset),
        .packet           (packet),
        .packet_valid     (packet_valid),
        .serializer_ready (serializer_ready),
        .O                (O),
        .OB               (OB)
    );

    initial begin
        clk4x = 1'b1;
        forever #1 clk4x = ~clk4x;
    end

    initial begin
        clk_128 = 1'b0;
        forever #4 clk_128 = ~clk_128;
    end

    always @(negedge clk4x) begin
        if (nbits < OBUF_N) obuf[nbits] <= O;
        if (OB !== ~O) ob_bad <= ob_bad + 1;
        nbits <= nbits + 1;
    end

`ifdef TELEM_FRAME_SERIALIZER_CRC_EN
    function automatic logic [7:0] crc_model(input logic [PW-1:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = PW - 1; i >= 0; i--) begin
            c = (c[7] ^ d[i]) ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    function automatic logic [FW-1:0] exp_frame(input logic [PW-1:0] p);
`ifdef TELEM_FRAME_SERIALIZER_CRC_EN
        return {16'hEB90, p, crc_model(p)};
`else
        return {16'hEB90, p};
`endif
    endfunction

    function automatic logic [FW-1:0] grab(input int s);
        logic [FW-1:0] v;
        for (int i = 0; i < FW; i++)
            v[FW-1-i] = (s + i < OBUF_N) ? obuf[s+i] : 1'bx;
        return v;
    endfunction

    function automatic int find_one(input int s, input int lim);
        for (int i = s; i < s + lim && i < OBUF_N; i++)
            if (obuf[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_nz(input int s, input int n);
        int c;
        c = 0;
        for (int i = s; i < s + n; i++)
            if (i >= OBUF_N || obuf[i] !== 1'b0) c++;
        return c;
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_128);
            if (serializer_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_one(input logic [PW-1:0] p, output int acc);
        packet       = p;
        packet_valid = 1'b1;
        @(posedge clk_128);
        acc = nbits;
        @(negedge clk_128);
        packet_valid = 1'b0;
        packet       = ~p;
    endtask

    task automatic test_reset();
        ft_reset     = 1'b1;
        packet_valid = 1'b0;
        packet       = '0;
        #100;
        total++; if (O !== 1'b0) begin bad++; $display("FAIL reset_O: got %b want 0", O); end
        total++; if (OB !== 1'b1) begin bad++; $display("FAIL reset_OB: got %b want 1", OB); end
        total++; if (serializer_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", serializer_ready); end
        @(negedge clk_128);
        #0.5 ft_reset = 1'b0;
        @(posedge clk_128);
        #1;
        total++; if (serializer_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_release: got %b want 1", serializer_ready); end
    endtask

    task automatic test_single();
        logic [PW-1:0] p;
        int acc, st, lowc;
        p    = 88'h0123456789ABCDEF012345;
        lowc = 0;
        send_one(p, acc);
        for (int i = 0; i < 100; i++) begin
            if (serializer_ready === 1'b1) break;
            lowc++;
            @(negedge clk_128);
        end
        total++; if (lowc !== NIB) begin bad++; $display("FAIL single_ready_low: got %0d cycles want %0d", lowc, NIB); end
        repeat (12) @(negedge clk_128);
        st = find_one(acc, 64);
        total++;
        if (st < 0) begin
            bad++; $display("FAIL single_start: got no frame want sync within 64 bits");
        end else begin
            lat_ref = st - acc;
            total++; if (grab(st) !== exp_frame(p)) begin bad++; $display("FAIL single_frame: got %h want %h", grab(st), exp_frame(p)); end
            total++; if (count_nz(st + FW, 32) !== 0) begin bad++; $display("FAIL single_tail: got %0d nonzero bits want 0", count_nz(st + FW, 32)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] p1, p2;
        int acc1, acc2, st1, st2;
        bit ok;
        p1 = 88'hC3A50F1E2D3C4B5A697887;
        p2 = '1;
        wait_ready(ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_ready: got timeout want ready=1"); end
        packet       = p1;
        packet_valid = 1'b1;
        @(posedge clk_128);
        acc1 = nbits;
        @(negedge clk_128);
        packet = p2;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (serializer_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk_128);
        end
        total++; if (!ok) begin bad++; $display("FAIL b2b_ready2: got timeout want ready=1"); end
        @(posedge clk_128);
        acc2 = nbits;
        @(negedge clk_128);
        packet_valid = 1'b0;
        packet       = '0;
        repeat (40) @(negedge clk_128);
        st1 = find_one(acc1, 64);
        total++;
        if (st1 < 0) begin
            bad++; $display("FAIL b2b_start: got no frame want sync within 64 bits");
        end else begin
            total++; if (st1 - acc1 !== lat_ref) begin bad++; $display("FAIL b2b_latency1: got %0d want %0d", st1 - acc1, lat_ref); end
            total++; if (grab(st1) !== exp_frame(p1)) begin bad++; $display("FAIL b2b_frame1: got %h want %h", grab(st1), exp_frame(p1)); end
            total++; if (count_nz(st1 + FW, 4) !== 0) begin bad++; $display("FAIL b2b_gap: got %0d nonzero bits want 0", count_nz(st1 + FW, 4)); end
            st2 = find_one(st1 + FW, 64);
            total++; if (st2 !== st1 + FW + 4) begin bad++; $display("FAIL b2b_gap_len: got start %0d want %0d", st2, st1 + FW + 4); end
            total++; if (grab(st1 + FW + 4) !== exp_frame(p2)) begin bad++; $display("FAIL b2b_frame2: got %h want %h", grab(st1 + FW + 4), exp_frame(p2)); end
            total++; if (st1 + FW + 4 - acc2 !== lat_ref) begin bad++; $display("FAIL b2b_latency2: got %0d want %0d", st1 + FW + 4 - acc2, lat_ref); end
        end
    endtask

    task automatic test_busy_ignore();
        logic [PW-1:0] p;
        int acc, st;
        bit ok;
        p = 88'h00FEDCBA9876543210ABCD;
        wait_ready(ok);
        total++; if (!ok) begin bad++; $display("FAIL busy_ready: got timeout want ready=1"); end
        send_one(p, acc);
        repeat (8) @(negedge clk_128);
        packet       = 88'hAAAAAAAAAAAAAAAAAAAAAA;
        packet_valid = 1'b1;
        @(negedge clk_128);
        packet_valid = 1'b0;
        packet       = '0;
        wait_ready(ok);
        total++; if (!ok) begin bad++; $display("FAIL busy_ready_end: got timeout want ready=1"); end
        repeat (40) @(negedge clk_128);
        total++; if (serializer_ready !== 1'b1) begin bad++; $display("FAIL busy_still_ready: got %b want 1", serializer_ready); end
        st = find_one(acc, 64);
        total++;
        if (st < 0) begin
            bad++; $display("FAIL busy_start: got no frame want sync within 64 bits");
        end else begin
            total++; if (grab(st) !== exp_frame(p)) begin bad++; $display("FAIL busy_frame: got %h want %h", grab(st), exp_frame(p)); end
            total++; if (count_nz(st + FW, 120) !== 0) begin bad++; $display("FAIL busy_no_second: got %0d nonzero bits want 0", count_nz(st + FW, 120)); end
            total++; if (st - acc !== lat_ref) begin bad++; $display("FAIL busy_latency: got %0d want %0d", st - acc, lat_ref); end
        end
    endtask

    task automatic test_reset_mid();
        logic [PW-1:0] p, p2;
        int acc, rel, st;
        bit ok;
        p  = 88'h3C3C5A5A9696C3C3F0F00F;
        p2 = 88'h8000000000000000000001;
        wait_ready(ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_ready: got timeout want ready=1"); end
        send_one(p, acc);
        repeat (10) @(posedge clk_128);
        #2;
        ft_reset = 1'b1;
        #0.2;
        total++; if (O !== 1'b0) begin bad++; $display("FAIL mid_reset_O: got %b want 0", O); end
        total++; if (OB !== 1'b1) begin bad++; $display("FAIL mid_reset_OB: got %b want 1", OB); end
        total++; if (serializer_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_ready: got %b want 0", serializer_ready); end
        repeat (3) @(negedge clk_128);
        #0.5 ft_reset = 1'b0;
        rel = nbits;
        repeat (30) @(negedge clk_128);
        total++; if (count_nz(rel, 100) !== 0) begin bad++; $display("FAIL mid_no_resume: got %0d nonzero bits want 0", count_nz(rel, 100)); end
        total++; if (serializer_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_after: got %b want 1", serializer_ready); end
        send_one(p2, acc);
        wait_ready(ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_ready_end: got timeout want ready=1"); end
        repeat (12) @(negedge clk_128);
        st = find_one(acc, 64);
        total++;
        if (st < 0) begin
            bad++; $display("FAIL mid_start: got no frame want sync within 64 bits");
        end else begin
            total++; if (grab(st) !== exp_frame(p2)) begin bad++; $display("FAIL mid_frame: got %h want %h", grab(st), exp_frame(p2)); end
            total++; if (st - acc !== lat_ref) begin bad++; $display("FAIL mid_latency: got %0d want %0d", st - acc, lat_ref); end
        end
    endtask

`ifdef TELEM_FRAME_SERIALIZER_CRC_EN
    task automatic test_crc();
        logic [FW-1:0] got;
        int acc, st;
        bit ok;
        logic [PW-1:0] pz, po;
        pz = '0;
        po = 88'h01;
        wait_ready(ok);
        send_one(pz, acc);
        wait_ready(ok);
        repeat (12) @(negedge clk_128);
        st = find_one(acc, 64);
        got = grab(st < 0 ? 0 : st);
        total++; if (got !== {16'hEB90, 88'h0, 8'h00}) begin bad++; $display("FAIL crc_zero_frame: got %h want crc 00 frame", got); end
        send_one(po, acc);
        wait_ready(ok);
        total++; if (!ok) begin bad++; $display("FAIL crc_ready: got timeout want ready=1"); end
        repeat (12) @(negedge clk_128);
        st = find_one(acc, 64);
        got = grab(st < 0 ? 0 : st);
        total++; if (got[7:0] !== 8'h07) begin bad++; $display("FAIL crc_one_value: got %h want 07", got[7:0]); end
        total++; if (got !== {16'hEB90, 88'h01, 8'h07}) begin bad++; $display("FAIL crc_one_frame: got %h want crc 07 frame", got); end
    endtask
`endif

    task automatic test_complement();
        total++; if (ob_bad !== 0) begin bad++; $display("FAIL ob_complement: got %0d bad cycles want 0", ob_bad); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
`ifdef TELEM_FRAME_SERIALIZER_CRC_EN
        test_crc();
`endif
        test_complement();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
